// File: rtl/cg_memory_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS read/write requesters onto one memory port.
// Read returns are steered back to their requester through an in-order route FIFO.
module cg_memory_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [NUM_PORTS-1:0]              s_raddr_valid,
    output logic [NUM_PORTS-1:0]              s_raddr_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_raddr,
    output logic [NUM_PORTS-1:0]              s_rdata_valid,
    input  logic [NUM_PORTS-1:0]              s_rdata_ready,
    output logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic [NUM_PORTS-1:0]              s_wdata_valid,
    output logic [NUM_PORTS-1:0]              s_wdata_ready,
    input  logic [NUM_PORTS-1:0]              s_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_waddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_wdata,
    output logic                              m_raddr_valid,
    input  logic                              m_raddr_ready,
    output logic [ADDR_WIDTH-1:0]             m_raddr,
    input  logic                              m_rdata_valid,
    output logic                              m_rdata_ready,
    input  logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              m_wdata_valid,
    input  logic                              m_wdata_ready,
    output logic                              m_wen,
    output logic [ADDR_WIDTH-1:0]             m_waddr,
    output logic [DATA_WIDTH-1:0]             m_wdata,
    output logic [$clog2(MAX_OUTSTANDING):0]  o_outstanding
);
    localparam int unsigned PW = $clog2(NUM_PORTS);
    localparam int unsigned QW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = QW + 1;

    logic [ADDR_WIDTH-1:0] raddr_arr [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] waddr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
        assign raddr_arr[k] = s_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign waddr_arr[k] = s_waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[k] = s_wdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after ptr, wrapping; falls back to ptr when nobody requests.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [PW-1:0]        ptr);
        logic [PW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
        return pick;
    endfunction

    logic [PW-1:0] rd_ptr, rd_lock_port, rd_grant;
    logic [PW-1:0] wr_ptr, wr_lock_port, wr_grant;
    logic          rd_lock, wr_lock, rd_hs, wr_hs, rd_pop;

    logic [PW-1:0] route_mem [MAX_OUTSTANDING];
    logic [QW-1:0] route_wr, route_rd;
    logic [CW-1:0] route_cnt;
    logic          route_full, route_empty;
    logic [PW-1:0] route_head;

    always_comb begin
        route_full  = (route_cnt == CW'(MAX_OUTSTANDING));
        route_empty = (route_cnt == '0);
        route_head  = route_mem[route_rd];

        // A stalled request keeps its grant so m_raddr stays stable until accepted.
        rd_grant = (rd_lock && s_raddr_valid[rd_lock_port]) ? rd_lock_port
                                                            : rr_pick(s_raddr_valid, rd_ptr);
        m_raddr_valid = i_rstn & (|s_raddr_valid) & ~route_full;
        m_raddr       = raddr_arr[rd_grant];
        s_raddr_ready = '0;
        s_raddr_ready[rd_grant] = i_rstn & m_raddr_ready & ~route_full;
        rd_hs = m_raddr_valid & m_raddr_ready;

        s_rdata       = m_rdata;
        s_rdata_valid = '0;
        s_rdata_valid[route_head] = i_rstn & m_rdata_valid & ~route_empty;
        m_rdata_ready = i_rstn & ~route_empty & s_rdata_ready[route_head];
        rd_pop        = m_rdata_valid & m_rdata_ready;

        wr_grant = (wr_lock && s_wdata_valid[wr_lock_port]) ? wr_lock_port
                                                            : rr_pick(s_wdata_valid, wr_ptr);
        m_wdata_valid = i_rstn & (|s_wdata_valid);
        m_wen         = s_wen[wr_grant];
        m_waddr       = waddr_arr[wr_grant];
        m_wdata       = wdata_arr[wr_grant];
        s_wdata_ready = '0;
        s_wdata_ready[wr_grant] = i_rstn & m_wdata_ready;
        wr_hs = m_wdata_valid & m_wdata_ready;
    end

    assign o_outstanding = route_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            rd_lock      <= 1'b0;
            wr_lock      <= 1'b0;
            rd_lock_port <= '0;
            wr_lock_port <= '0;
            route_wr     <= '0;
            route_rd     <= '0;
            route_cnt    <= '0;
        end else begin
            if (rd_hs) begin
                rd_ptr  <= (rd_grant == PW'(NUM_PORTS - 1)) ? '0 : rd_grant + 1'b1;
                rd_lock <= 1'b0;
            end else if (m_raddr_valid) begin
                rd_lock      <= 1'b1;
                rd_lock_port <= rd_grant;
            end else begin
                rd_lock <= 1'b0;
            end

            if (wr_hs) begin
                wr_ptr  <= (wr_grant == PW'(NUM_PORTS - 1)) ? '0 : wr_grant + 1'b1;
                wr_lock <= 1'b0;
            end else if (m_wdata_valid) begin
                wr_lock      <= 1'b1;
                wr_lock_port <= wr_grant;
            end else begin
                wr_lock <= 1'b0;
            end

            if (rd_hs)  route_wr <= route_wr + 1'b1;
            if (rd_pop) route_rd <= route_rd + 1'b1;
            case ({rd_hs, rd_pop})
                2'b10:   route_cnt <= route_cnt + 1'b1;
                2'b01:   route_cnt <= route_cnt - 1'b1;
                default: route_cnt <= route_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (rd_hs) route_mem[route_wr] <= rd_grant;
    end

endmodule

// File: doc/cg_memory_arbiter.md
CG_MEMORY_ARBITER -- requirements
Module: cg_memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of read/write data.
REQ-002 Parameter ADDR_WIDTH, default 32, width of read/write address.
REQ-003 Parameter NUM_PORTS, default 4, number of upstream requesters, legal range 2..16.
REQ-004 Parameter MAX_OUTSTANDING, default 4, read-return route FIFO depth, power of two, at least 2.
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rstn  in  1  asynchronous active-low reset.
REQ-007 s_raddr_valid/s_raddr_ready  in/out  NUM_PORTS  per-port read-address handshake.
REQ-008 s_raddr  in  NUM_PORTS*ADDR_WIDTH  per-port read address; port k occupies slice k.
REQ-009 s_rdata_valid/s_rdata_ready  out/in  NUM_PORTS  per-port read-data handshake.
REQ-010 s_rdata  out  DATA_WIDTH  read data, broadcast to all ports.
REQ-011 s_wdata_valid/s_wdata_ready  in/out  NUM_PORTS  per-port write handshake.
REQ-012 s_wen  in  NUM_PORTS  per-port write enable.
REQ-013 s_waddr/s_wdata  in  NUM_PORTS*ADDR_WIDTH / NUM_PORTS*DATA_WIDTH  per-port write address and data.
REQ-014 m_raddr_valid/m_raddr_ready/m_raddr  out/in/out  1/1/ADDR_WIDTH  downstream read address.
REQ-015 m_rdata_valid/m_rdata_ready/m_rdata  in/out/in  1/1/DATA_WIDTH  downstream read data, returned in request order.
REQ-016 m_wdata_valid/m_wdata_ready/m_wen/m_waddr/m_wdata  out/in/out/out/out  downstream write channel.
REQ-017 o_outstanding  out  $clog2(MAX_OUTSTANDING)+1  count of issued, unreturned reads.

Function
REQ-018 Read-address arbitration SHALL be round-robin: candidate search starts at port rd_ptr, ascending with wrap to 0.
REQ-019 On read-address handshake (m_raddr_valid & m_raddr_ready), rd_ptr SHALL become (granted port + 1) mod NUM_PORTS.
REQ-020 m_raddr_valid SHALL equal (any s_raddr_valid) & ~route_full; m_raddr SHALL be the granted port's address.
REQ-021 s_raddr_ready[k] SHALL be m_raddr_ready & ~route_full & (k == grant); all other ports 0.
REQ-022 Once m_raddr_valid is high without m_raddr_ready, the read grant SHALL be locked (registered) until handshake; new higher-priority requests SHALL NOT change m_raddr.
REQ-023 Each read-address handshake SHALL push the granted port index into the route FIFO the same edge.
REQ-024 route_full (count == MAX_OUTSTANDING) SHALL block pushes even if a pop occurs in the same cycle.
REQ-025 s_rdata_valid[head] SHALL equal m_rdata_valid & ~route_empty; all other ports 0; s_rdata = m_rdata combinationally (zero latency).
REQ-026 m_rdata_ready SHALL equal ~route_empty & s_rdata_ready[head]; handshake pops the FIFO.
REQ-027 m_rdata_valid while route FIFO empty SHALL be ignored (m_rdata_ready = 0, no s_rdata_valid).
REQ-028 Simultaneous push and pop when not full SHALL leave count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-029 o_outstanding SHALL equal route FIFO count.
REQ-030 Write channel SHALL use an independent round-robin pointer wr_ptr with identical rules to REQ-018, REQ-019 and REQ-022, without a FIFO limit.
REQ-031 m_wdata_valid SHALL be any s_wdata_valid; m_wen/m_waddr/m_wdata SHALL be the granted port's; s_wdata_ready[k] = m_wdata_ready & (k == write grant).
REQ-032 Read and write channels SHALL operate concurrently with no ordering between them.

Reset
REQ-033 While i_rstn low: rd_ptr = wr_ptr = 0, grant locks cleared, route FIFO empty, o_outstanding = 0.
REQ-034 While i_rstn low, all valid and ready outputs SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL discard outstanding routes; returns arriving after release with an empty FIFO fall under REQ-027.

Verification
REQ-036 Ports 0..3 request reads simultaneously, m_raddr_ready=1 -> grants 0,1,2,3 on consecutive cycles, o_outstanding reaches 4, then m_raddr_valid=0.
REQ-037 With 4 outstanding (0,1,2,3), return data A,B,C,D -> s_rdata_valid pulses on ports 0,1,2,3 in order with s_rdata A..D; o_outstanding falls to 0.
REQ-038 Port 2 valid with m_raddr_ready=0 for 3 cycles, port 0 asserts in cycle 2 -> m_raddr stays port 2's address until handshake; port 0 granted next.
REQ-039 FIFO full with simultaneous pop and new request -> request not accepted that cycle, accepted next cycle; count 4->3->4.
REQ-040 Ports 1 and 3 write concurrently with a port 0 read -> both writes complete in order 1 then 3; read is unaffected.
REQ-041 Reset pulsed with 2 outstanding -> o_outstanding = 0; a later m_rdata_valid is not acknowledged.
